// File: rtl/pipeline_pkg.sv
// Shared constants and payload layout for the pipeline stage register.
package pipeline_pkg;

  // Bit positions inside the side-effect enable vector.
  localparam int FX_REGFILE_WE = 0;
  localparam int FX_ITCM_WE    = 1;

  // Default widths used by the stage and its counter.
  localparam int DATA_W_DEF = 128;
  localparam int FX_W_DEF   = 2;
  localparam int CNT_W_DEF  = 16;

  // Default packing of the stage payload (sums to DATA_W_DEF bits).
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic [19:0] immediate;
    logic [4:0]  rd;
    logic [6:0]  controls;
  } stage_payload_t;

endpackage

// File: rtl/pipeline_stall_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module pipeline_stall_counter
  import pipeline_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline stage register with 1-cycle latency.
// Handshake: a beat moves on a posedge where valid && ready; valid may not
// depend on ready, and flush discards held beats without affecting in_ready.
// Build option: define PIPELINE_STAGE_SKID_EN for the two-entry skid build
// (in_ready comes straight from a flop); otherwise a single entry is held and
// in_ready = !out_valid || out_ready.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FX_W   = FX_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [FX_W-1:0]   in_fx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FX_W-1:0]   out_fx,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic [FX_W-1:0]   main_fx_q,    main_fx_d;
  logic              accept_w;
  logic              release_w;

  assign release_w = main_valid_q && out_ready;
  assign accept_w  = in_valid && in_ready;

`ifdef PIPELINE_STAGE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [FX_W-1:0]   skid_fx_q,    skid_fx_d;

  assign in_ready = !skid_valid_q;

  // Next state for main and skid entries; flush wins over accept/release.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_fx_d    = main_fx_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_fx_d    = skid_fx_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (release_w) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_fx_d    = skid_fx_q;
        skid_valid_d = accept_w;
        skid_data_d  = in_data;
        skid_fx_d    = in_fx;
      end else if (accept_w) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_fx_d    = in_fx;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_w) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_fx_d    = in_fx;
      end else begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
        main_fx_d    = in_fx;
      end
    end
  end

  // Skid entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_fx_q    <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_fx_q    <= skid_fx_d;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  // Next state for the single entry; flush wins over accept/release.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_fx_d    = main_fx_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept_w) begin
      main_valid_d = 1'b1;
      main_data_d  = in_data;
      main_fx_d    = in_fx;
    end else if (release_w) begin
      main_valid_d = 1'b0;
    end
  end
`endif

  // Main entry registers; data is kept after release so out_data holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_fx_q    <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_fx_q    <= main_fx_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_fx    = main_fx_q & {FX_W{main_valid_q}};

  pipeline_stall_counter #(
    .CNT_W (CNT_W)
  ) u_stall_counter (
    .clk   (clk),
    .rst   (rst),
    .inc   (main_valid_q && !out_ready),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Testbench for pipeline_stage_reg (either build of PIPELINE_STAGE_SKID_EN).
module tb_pipeline_stage_reg;

  localparam int DW  = 128;
  localparam int FW  = 2;
  localparam int CW  = 4;
  localparam int SAT = 15;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [FW-1:0] in_fx;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [FW-1:0] out_fx;
  logic [CW-1:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: ordered list of held beats, last presented data, count.
  logic [DW-1:0] exp_q[$];
  logic [FW-1:0] exp_fx_q[$];
  logic [DW-1:0] m_last;
  int            m_cnt;

  pipeline_stage_reg #(.DATA_W(DW), .FX_W(FW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_fx     (in_fx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_fx    (out_fx),
    .stall_cnt (stall_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic exp_ready();
    if (CAP == 1) return (exp_q.size() == 0) || out_ready;
    return exp_q.size() < 2;
  endfunction

  function automatic logic exp_valid();
    return exp_q.size() > 0;
  endfunction

  function automatic logic [FW-1:0] exp_fx();
    return (exp_q.size() > 0) ? exp_fx_q[0] : '0;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_in(input logic v, input logic [DW-1:0] d,
                        input logic [FW-1:0] fx, input logic ordy,
                        input logic fl);
    in_valid  = v;
    in_data   = d;
    in_fx     = fx;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Advance one cycle: update the model from current inputs, then clock.
  task automatic tick();
    logic acc, rel;
    acc = in_valid && exp_ready();
    rel = exp_valid() && out_ready;
    if (exp_valid() && !out_ready && m_cnt < SAT) m_cnt++;
    if (flush) begin
      exp_q.delete();
      exp_fx_q.delete();
    end else begin
      if (rel) begin
        void'(exp_q.pop_front());
        void'(exp_fx_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(in_data);
        exp_fx_q.push_back(in_fx);
      end
    end
    if (exp_q.size() > 0) m_last = exp_q[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_fx_q.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_fx !== 2'b00) $display("FAIL reset_out_fx got %0b want 00", out_fx); else pass_cnt++;
    total_cnt++; if (out_data !== '0) $display("FAIL reset_out_data got %0h want 0", out_data); else pass_cnt++;
    total_cnt++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_fx_q.delete();
    m_last = '0;
    m_cnt  = 0;
  endtask

  task automatic test_single();
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    set_in(1'b1, a5, 2'b11, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, 2'b11, 1'b1, 1'b0);
    #1;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== a5) $display("FAIL single_data got %0h want %0h", out_data, a5); else pass_cnt++;
    total_cnt++; if (out_fx !== 2'b11) $display("FAIL single_fx got %0b want 11", out_fx); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL idle_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_fx !== 2'b00) $display("FAIL idle_fx got %0b want 00", out_fx); else pass_cnt++;
    total_cnt++; if (out_data !== a5) $display("FAIL idle_data_hold got %0h want %0h", out_data, a5); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 9; i++) begin
      set_in(i <= 8, DW'(i), 2'b01, 1'b1, 1'b0);
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_ready cyc %0d got %0b want 1", i, in_ready); else pass_cnt++;
      if (i > 1) begin
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== DW'(i - 1))
          $display("FAIL b2b_beat cyc %0d got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i - 1);
        else pass_cnt++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    reset_dut();
    set_in(1'b1, DW'(1), 2'b10, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, DW'(2), 2'b01, 1'b0, 1'b0);
      #1;
      total_cnt++; if (in_ready !== exp_ready()) $display("FAIL stall_ready cyc %0d got %0b want %0b", i, in_ready, exp_ready()); else pass_cnt++;
      if (i == 2) begin
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_full_ready got %0b want 0", in_ready); else pass_cnt++;
      end
      tick();
    end
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    total_cnt++; if (stall_cnt !== CW'(3)) $display("FAIL stall_cnt3 got %0d want 3", stall_cnt); else pass_cnt++;
    total_cnt++; if (out_data !== DW'(1) || out_valid !== 1'b1) $display("FAIL stall_first_out got v=%0b d=%0h want v=1 d=1", out_valid, out_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (out_valid !== exp_valid() || (exp_valid() && out_data !== m_last) || out_fx !== exp_fx())
        $display("FAIL stall_drain cyc %0d got v=%0b d=%0h fx=%0b want v=%0b d=%0h fx=%0b",
                 i, out_valid, out_data, out_fx, exp_valid(), m_last, exp_fx());
      else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_flush();
    reset_dut();
    set_in(1'b1, DW'(16'h1111), 2'b11, 1'b0, 1'b0);
    tick();
    set_in(1'b1, DW'(16'h2222), 2'b11, 1'b0, 1'b1);
    #1;
    total_cnt++; if (in_ready !== exp_ready()) $display("FAIL flush_ready_indep got %0b want %0b", in_ready, exp_ready()); else pass_cnt++;
    tick();
    set_in(1'b0, '0, 2'b11, 1'b1, 1'b0);
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_fx !== 2'b00) $display("FAIL flush_fx got %0b want 00", out_fx); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_no_new_beat got %0b want 0", out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), rnd_data(), 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      #1;
      total_cnt++;
      if (in_ready !== exp_ready() || out_valid !== exp_valid() || out_fx !== exp_fx() ||
          out_data !== m_last || stall_cnt !== CW'(m_cnt)) begin
        errs++;
        if (errs <= 5)
          $display("FAIL random cyc %0d got r=%0b v=%0b fx=%0b d=%0h c=%0d want r=%0b v=%0b fx=%0b d=%0h c=%0d",
                   i, in_ready, out_valid, out_fx, out_data, stall_cnt,
                   exp_ready(), exp_valid(), exp_fx(), m_last, m_cnt);
      end else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_saturate_and_reset();
    reset_dut();
    set_in(1'b1, DW'(16'h7777), 2'b11, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
    end
    #1;
    total_cnt++; if (stall_cnt !== CW'(SAT)) $display("FAIL stall_sat got %0d want %0d", stall_cnt, SAT); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL sat_held got %0b want 1", out_valid); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || out_fx !== '0 || out_data !== '0 || stall_cnt !== '0)
      $display("FAIL async_reset got v=%0b fx=%0b d=%0h c=%0d want all 0", out_valid, out_fx, out_data, stall_cnt);
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_fx_q.delete();
    m_last = '0;
    m_cnt  = 0;
    set_in(1'b1, DW'(16'h5A5A), 2'b01, 1'b1, 1'b0);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    total_cnt++;
    if (out_valid !== 1'b1 || out_data !== DW'(16'h5A5A) || out_fx !== 2'b01)
      $display("FAIL first_accept got v=%0b d=%0h fx=%0b want v=1 d=5a5a fx=01", out_valid, out_data, out_fx);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 128: payload width in bits (pc4, rd, alu_result, immediate, rs2_data, controls).
REQ-002 SHALL have parameter FX_W, default 2: side-effect enable width (regfile_we, itcm_we); each bit is squashed when the beat is invalid.
REQ-003 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 flush  input  1  discard every held beat this cycle.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_fx  input  FX_W  upstream side-effect enables.
REQ-011 out_valid  output  1  held beat is valid.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_data  output  DATA_W  held payload.
REQ-014 out_fx  output  FX_W  held side-effect enables, gated by out_valid.
REQ-015 stall_cnt  output  CNT_W  count of downstream-stalled cycles.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready at posedge; release SHALL occur when out_valid && out_ready at posedge.
REQ-017 Latency SHALL be 1 cycle: a beat accepted into an empty stage is presented on out_* the next cycle.
REQ-018 Accept and release in the same cycle SHALL sustain 1 beat/cycle with no bubble.
REQ-019 out_fx SHALL be all-zero whenever out_valid=0; out_data SHALL hold its last value when not valid.
REQ-020 in_valid=0 SHALL never load an entry or raise out_valid.
REQ-021 flush=1 SHALL clear every entry valid at the next posedge, with priority over a simultaneous accept (incoming beat dropped) and release.
REQ-022 in_ready SHALL NOT depend on flush.
REQ-023 stall_cnt SHALL increment by 1 each cycle with out_valid && !out_ready, saturate at 2^CNT_W-1, and not wrap.
REQ-024 stall_cnt SHALL NOT clear on flush.
REQ-025 Without the skid, the stage SHALL hold one entry, with in_ready = !out_valid || out_ready (combinational).
REQ-026 With the skid, the stage SHALL hold main and skid entries.
REQ-027 With the skid, in_ready SHALL equal !skid_valid, driven from a flop only.
REQ-028 With the skid, a beat accepted while main is valid and not released SHALL go to skid.
REQ-029 With the skid, on main release with skid valid, skid SHALL move to main and an input beat accepted that cycle SHALL go to skid.
REQ-030 Beat order SHALL be preserved in all cases.

Reset
REQ-031 On rst high, immediately and without clk: all valids 0, out_valid 0, out_fx 0, out_data 0, stall_cnt 0.
REQ-032 On rst high, in_ready SHALL be 1 (skid build) or 1 (non-skid build, by REQ-025).
REQ-033 Reset asserted mid-transfer SHALL drop all held beats.
REQ-034 The first accept SHALL be possible on the first posedge after rst deasserts.

Configuration
REQ-035 Macro PIPELINE_STAGE_SKID_EN SHALL select the build.
REQ-036 With PIPELINE_STAGE_SKID_EN defined: two-entry skid build (REQ-026..REQ-029); no combinational out_ready->in_ready path.
REQ-037 Without PIPELINE_STAGE_SKID_EN: single-entry build (REQ-025).
REQ-038 Ports and latency SHALL be identical in both builds.

Structure
REQ-039 Package pipeline_pkg SHALL hold FX bit index constants (FX_REGFILE_WE=0, FX_ITCM_WE=1), DATA_W/FX_W/CNT_W defaults, and the stage payload struct typedef.
REQ-040 Saturating counter SHALL be sub-module pipeline_stall_counter (clk, rst, inc, count).

Verification
REQ-041 in_valid=1, in_data=0xA5.., in_fx=2'b11, out_ready=1 -> next cycle out_valid=1, out_data=0xA5.., out_fx=2'b11.
REQ-042 in_valid=0, in_fx=2'b11 -> out_valid=0, out_fx=2'b00.
REQ-043 Stream beats 1..8, out_ready=1 -> beats out 1..8 on consecutive cycles, no gaps.
REQ-044 Hold out_ready=0 for 3 cycles with a beat held -> stall_cnt=3. With skid: 2nd beat taken, then in_ready=0; on out_ready=1, beats out in order.
REQ-045 flush=1 with in_valid=1 and a beat held -> next cycle out_valid=0, out_fx=0, new beat absent.
REQ-046 CNT_W=4, out_ready=0 for 20 stalled cycles -> stall_cnt=15. Then rst pulse mid-stall -> all outputs 0 immediately, before the next clk edge.
